// File: rtl/cp0_irq_if.sv
// Register-file and exception-commit bundle between the pipeline and coprocessor 0.
interface cp0_irq_if #(
   parameter int HW_IRQ_NUM = 6
);
   logic [7:0]            raddr;
   logic [31:0]           rdata;
   logic                  wen;
   logic [7:0]            waddr;
   logic [31:0]           wdata;
   logic [HW_IRQ_NUM-1:0] hw_int;
   logic                  exp_en;
   logic                  exp_badvaddr_en;
   logic [31:0]           exp_badvaddr;
   logic                  exp_bd;
   logic [4:0]            exp_code;
   logic [31:0]           exp_epc;
   logic                  eret;
   logic                  int_req;
   logic [31:0]           epc_out;
   logic                  exl_out;

   modport master (
      output raddr, wen, waddr, wdata, hw_int, exp_en, exp_badvaddr_en,
             exp_badvaddr, exp_bd, exp_code, exp_epc, eret,
      input  rdata, int_req, epc_out, exl_out
   );

   modport slave (
      input  raddr, wen, waddr, wdata, hw_int, exp_en, exp_badvaddr_en,
             exp_badvaddr, exp_bd, exp_code, exp_epc, eret,
      output rdata, int_req, epc_out, exl_out
   );
endinterface

// File: rtl/cp0_irq.sv
// Coprocessor 0: BadVAddr/Count/Compare/Status/Cause/EPC, prescaled timer,
// hardware interrupt sampling, exception entry and ERET.
module cp0_irq #(
   parameter int HW_IRQ_NUM = 6,
   parameter int COUNT_DIV  = 2
) (
   input logic       clk,
   input logic       rst,
   cp0_irq_if.slave  bus
);
   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(COUNT_DIV - 1);

   localparam logic [7:0] A_BADVADDR = 8'h40;
   localparam logic [7:0] A_COUNT    = 8'h48;
   localparam logic [7:0] A_COMPARE  = 8'h58;
   localparam logic [7:0] A_STATUS   = 8'h60;
   localparam logic [7:0] A_CAUSE    = 8'h68;
   localparam logic [7:0] A_EPC      = 8'h70;

   logic [31:0]           badvaddr, count, compare, epc;
   logic [7:0]            im;
   logic                  exl, ie;
   logic                  bd, ti;
   logic [1:0]            sw;
   logic [4:0]            exc;
   logic [HW_IRQ_NUM-1:0] hw_q;
   logic [PW-1:0]         presc;

   logic                  tick;
   logic [7:0]            ip;
   logic                  wr_count, wr_compare, wr_status, wr_cause, wr_epc;

   assign tick       = (presc == PMAX);
   assign wr_count   = bus.wen && (bus.waddr == A_COUNT);
   assign wr_compare = bus.wen && (bus.waddr == A_COMPARE);
   assign wr_status  = bus.wen && (bus.waddr == A_STATUS);
   assign wr_cause   = bus.wen && (bus.waddr == A_CAUSE);
   assign wr_epc     = bus.wen && (bus.waddr == A_EPC);

   // Line i lands on IP[2+i]; with six lines the last one shares IP[7] with the timer.
   always_comb begin
      ip      = '0;
      ip[1:0] = sw;
      for (int i = 0; i < HW_IRQ_NUM; i++) begin
         ip[2+i] = hw_q[i];
      end
      ip[7] = ip[7] | ti;
   end

   always_comb begin
      bus.rdata = '0;
      case (bus.raddr)
         A_BADVADDR: bus.rdata = badvaddr;
         A_COUNT:    bus.rdata = count;
         A_COMPARE:  bus.rdata = compare;
         A_STATUS:   bus.rdata = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
         A_CAUSE:    bus.rdata = {bd, ti, 14'b0, ip, 1'b0, exc, 2'b0};
         A_EPC:      bus.rdata = epc;
         default:    bus.rdata = '0;
      endcase
   end

   assign bus.int_req = ie & ~exl & (|(ip & im));
   assign bus.epc_out = epc;
   assign bus.exl_out = exl;

   always_ff @(posedge clk) begin
      if (rst) begin
         badvaddr <= '0;
         count    <= '0;
         compare  <= '0;
         epc      <= '0;
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ti       <= 1'b0;
         sw       <= '0;
         exc      <= '0;
         hw_q     <= '0;
         presc    <= '0;
      end else begin
         hw_q <= bus.hw_int;

         if (wr_count) begin
            count <= bus.wdata;
            presc <= '0;
         end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) count <= count + 32'd1;
         end

         if (wr_compare) compare <= bus.wdata;

         // A Compare write acknowledges the timer even if a match lands this cycle.
         if (wr_compare)
            ti <= 1'b0;
         else if (tick && (count + 32'd1 == compare))
            ti <= 1'b1;

         if (wr_status) begin
            im <= bus.wdata[15:8];
            ie <= bus.wdata[0];
         end

         if (bus.exp_en)
            exl <= 1'b1;
         else if (bus.eret)
            exl <= 1'b0;
         else if (wr_status)
            exl <= bus.wdata[1];

         if (wr_cause) sw <= bus.wdata[1:0];

         // A nested exception keeps the outer EPC/BD so ERET returns to the original context.
         if (bus.exp_en) begin
            exc <= bus.exp_code;
            if (!exl) begin
               epc <= bus.exp_epc;
               bd  <= bus.exp_bd;
            end
            if (bus.exp_badvaddr_en) badvaddr <= bus.exp_badvaddr;
         end else if (wr_epc) begin
            epc <= bus.wdata;
         end
      end
   end
endmodule

// File: tb/tb_cp0_irq.sv
// Directed bench for cp0_irq: instance A (6 lines, divide-by-2), instance B (2 lines, divide-by-1).
module tb_cp0_irq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0]  raddr = '0;
   logic        wen = 1'b0;
   logic [7:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [5:0]  hw_a = '0;
   logic [1:0]  hw_b = '0;
   logic        exp_en = 1'b0;
   logic        exp_badvaddr_en = 1'b0;
   logic [31:0] exp_badvaddr = '0;
   logic        exp_bd = 1'b0;
   logic [4:0]  exp_code = '0;
   logic [31:0] exp_epc = '0;
   logic        eret = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   cp0_irq_if #(.HW_IRQ_NUM(6)) ia ();
   cp0_irq_if #(.HW_IRQ_NUM(2)) ib ();

   assign ia.raddr = raddr;           assign ib.raddr = raddr;
   assign ia.wen = wen;               assign ib.wen = wen;
   assign ia.waddr = waddr;           assign ib.waddr = waddr;
   assign ia.wdata = wdata;           assign ib.wdata = wdata;
   assign ia.hw_int = hw_a;           assign ib.hw_int = hw_b;
   assign ia.exp_en = exp_en;         assign ib.exp_en = exp_en;
   assign ia.exp_badvaddr_en = exp_badvaddr_en;
   assign ib.exp_badvaddr_en = exp_badvaddr_en;
   assign ia.exp_badvaddr = exp_badvaddr;
   assign ib.exp_badvaddr = exp_badvaddr;
   assign ia.exp_bd = exp_bd;         assign ib.exp_bd = exp_bd;
   assign ia.exp_code = exp_code;     assign ib.exp_code = exp_code;
   assign ia.exp_epc = exp_epc;       assign ib.exp_epc = exp_epc;
   assign ia.eret = eret;             assign ib.eret = eret;

   cp0_irq #(.HW_IRQ_NUM(6), .COUNT_DIV(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   cp0_irq #(.HW_IRQ_NUM(2), .COUNT_DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   localparam logic [7:0] A_BADVADDR = 8'h40, A_COUNT = 8'h48, A_RD10 = 8'h50,
                          A_COMPARE = 8'h58, A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] va, output logic [31:0] vb);
      raddr = a;
      #1;
      va = ia.rdata;
      vb = ib.rdata;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      wen = 1'b1; waddr = a; wdata = d;
      step();
      wen = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] va, vb;
      logic [7:0]  addrs [7] = '{A_BADVADDR, A_COUNT, A_COMPARE, A_STATUS, A_CAUSE, A_EPC, A_RD10};
      logic [31:0] exps  [7] = '{32'h0, 32'h0, 32'h0, 32'h0040_0000, 32'h0, 32'h0, 32'h0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         rd(addrs[i], va, vb);
         n_chk++;
         if (va !== exps[i]) $display("FAIL reset_read addr=%h got %h want %h", addrs[i], va, exps[i]);
         else n_pass++;
      end
      n_chk++;
      if ({ia.int_req, ia.exl_out, ia.epc_out} !== 34'h0)
         $display("FAIL reset_outputs got %b/%b/%h want 0/0/0", ia.int_req, ia.exl_out, ia.epc_out);
      else n_pass++;
      wr(A_BADVADDR, 32'h1234);
      rd(A_BADVADDR, va, vb);
      n_chk++;
      if (va !== 32'h0) $display("FAIL badvaddr_readonly got %h want 0", va);
      else n_pass++;
   endtask

   task automatic test_count();
      logic [31:0] va, vb;
      do_reset();
      repeat (10) step();
      rd(A_COUNT, va, vb);
      n_chk++;
      if (va !== 32'd5) $display("FAIL count_div2 got %0d want 5", va);
      else n_pass++;
      n_chk++;
      if (vb !== 32'd10) $display("FAIL count_div1 got %0d want 10", vb);
      else n_pass++;
      wr(A_COUNT, 32'hFFFF_FFFF);
      step();
      step();
      rd(A_COUNT, va, vb);
      n_chk++;
      if (va !== 32'h0) $display("FAIL count_wrap got %h want 0", va);
      else n_pass++;
      step();
      wr(A_COUNT, 32'h100);
      rd(A_COUNT, va, vb);
      n_chk++;
      if (va !== 32'h100) $display("FAIL count_write_on_tick got %h want 100", va);
      else n_pass++;
      step();
      step();
      rd(A_COUNT, va, vb);
      n_chk++;
      if (va !== 32'h101) $display("FAIL count_after_load got %h want 101", va);
      else n_pass++;
   endtask

   task automatic test_timer();
      logic [31:0] va, vb;
      do_reset();
      wr(A_COMPARE, 32'd3);
      wr(A_STATUS, 32'h0000_8001);
      rd(A_CAUSE, va, vb);
      n_chk++;
      if ({vb[30], ib.int_req} !== 2'b00) $display("FAIL timer_before got %b want 00", {vb[30], ib.int_req});
      else n_pass++;
      step();
      rd(A_COUNT, va, vb);
      n_chk++;
      if (vb !== 32'd3) $display("FAIL timer_count got %0d want 3", vb);
      else n_pass++;
      rd(A_CAUSE, va, vb);
      n_chk++;
      if ({vb[30], ib.int_req} !== 2'b11) $display("FAIL timer_rise got %b want 11", {vb[30], ib.int_req});
      else n_pass++;
      step();
      rd(A_CAUSE, va, vb);
      n_chk++;
      if (vb[30] !== 1'b1) $display("FAIL timer_sticky got %b want 1", vb[30]);
      else n_pass++;
      wr(A_COMPARE, 32'd100);
      rd(A_CAUSE, va, vb);
      n_chk++;
      if ({vb[30], ib.int_req} !== 2'b00) $display("FAIL timer_clear got %b want 00", {vb[30], ib.int_req});
      else n_pass++;
      wr(A_COUNT, 32'd10);
      wr(A_COMPARE, 32'd12);
      wr(A_COMPARE, 32'd50);
      rd(A_COUNT, va, vb);
      n_chk++;
      if (vb !== 32'd12) $display("FAIL timer_match_count got %0d want 12", vb);
      else n_pass++;
      rd(A_CAUSE, va, vb);
      n_chk++;
      if (vb[30] !== 1'b0) $display("FAIL timer_clear_wins got %b want 0", vb[30]);
      else n_pass++;
   endtask

   task automatic test_hw_irq();
      logic [31:0] va, vb;
      do_reset();
      hw_b = 2'b10;
      hw_a = 6'b111111;
      wr(A_STATUS, 32'h0000_0801);
      rd(A_CAUSE, va, vb);
      n_chk++;
      if (vb !== 32'h0000_0800) $display("FAIL hw_cause_b got %h want 00000800", vb);
      else n_pass++;
      n_chk++;
      if (ib.int_req !== 1'b1) $display("FAIL hw_int_req got %b want 1", ib.int_req);
      else n_pass++;
      n_chk++;
      if (va !== 32'h0000_FC00) $display("FAIL hw_cause_a got %h want 0000fc00", va);
      else n_pass++;
      wr(A_STATUS, 32'h0000_0803);
      n_chk++;
      if (ib.int_req !== 1'b0) $display("FAIL hw_exl_mask got %b want 0", ib.int_req);
      else n_pass++;
      wr(A_STATUS, 32'h0000_0401);
      n_chk++;
      if (ib.int_req !== 1'b0) $display("FAIL hw_im_mask got %b want 0", ib.int_req);
      else n_pass++;
      hw_b = 2'b00;
      hw_a = '0;
      step();
      rd(A_CAUSE, va, vb);
      n_chk++;
      if (vb !== 32'h0) $display("FAIL hw_release got %h want 0", vb);
      else n_pass++;
   endtask

   task automatic test_exception();
      logic [31:0] va, vb;
      do_reset();
      exp_en = 1'b1; exp_epc = 32'hBFC0_0100; exp_bd = 1'b1; exp_code = 5'h0C;
      exp_badvaddr_en = 1'b1; exp_badvaddr = 32'hDEAD_0000;
      step();
      exp_en = 1'b0; exp_badvaddr_en = 1'b0;
      rd(A_EPC, va, vb);
      n_chk++;
      if (va !== 32'hBFC0_0100) $display("FAIL exc_epc got %h want bfc00100", va);
      else n_pass++;
      rd(A_CAUSE, va, vb);
      n_chk++;
      if (va !== 32'h8000_0030) $display("FAIL exc_cause got %h want 80000030", va);
      else n_pass++;
      rd(A_BADVADDR, va, vb);
      n_chk++;
      if (va !== 32'hDEAD_0000) $display("FAIL exc_badvaddr got %h want dead0000", va);
      else n_pass++;
      n_chk++;
      if (ia.exl_out !== 1'b1) $display("FAIL exc_exl got %b want 1", ia.exl_out);
      else n_pass++;
      exp_en = 1'b1; exp_epc = 32'h8000_0000; exp_bd = 1'b0; exp_code = 5'h04;
      step();
      exp_en = 1'b0;
      rd(A_EPC, va, vb);
      n_chk++;
      if (va !== 32'hBFC0_0100) $display("FAIL nested_epc got %h want bfc00100", va);
      else n_pass++;
      rd(A_CAUSE, va, vb);
      n_chk++;
      if (va !== 32'h8000_0010) $display("FAIL nested_cause got %h want 80000010", va);
      else n_pass++;
      eret = 1'b1;
      step();
      eret = 1'b0;
      n_chk++;
      if ({ia.exl_out, ia.epc_out} !== {1'b0, 32'hBFC0_0100})
         $display("FAIL eret got exl=%b epc=%h want exl=0 epc=bfc00100", ia.exl_out, ia.epc_out);
      else n_pass++;
   endtask

   task automatic test_priority();
      logic [31:0] va, vb;
      do_reset();
      exp_en = 1'b1; eret = 1'b1; exp_epc = 32'h2000; exp_code = 5'h01;
      wen = 1'b1; waddr = A_STATUS; wdata = 32'h0;
      step();
      exp_en = 1'b0; eret = 1'b0; wen = 1'b0;
      rd(A_STATUS, va, vb);
      n_chk++;
      if (va !== 32'h0040_0002) $display("FAIL prio_exl got %h want 00400002", va);
      else n_pass++;
      eret = 1'b1;
      step();
      eret = 1'b0;
      exp_en = 1'b1; exp_epc = 32'h1000;
      wen = 1'b1; waddr = A_EPC; wdata = 32'h55;
      step();
      exp_en = 1'b0; wen = 1'b0;
      rd(A_EPC, va, vb);
      n_chk++;
      if (va !== 32'h1000) $display("FAIL prio_epc got %h want 1000", va);
      else n_pass++;
      eret = 1'b1;
      step();
      eret = 1'b0;
      exp_en = 1'b1; exp_epc = 32'h3000;
      wen = 1'b1; waddr = A_COMPARE; wdata = 32'd7;
      step();
      exp_en = 1'b0; wen = 1'b0;
      rd(A_COMPARE, va, vb);
      n_chk++;
      if (va !== 32'd7) $display("FAIL prio_compare got %0d want 7", va);
      else n_pass++;
      n_chk++;
      if ({ia.exl_out, ia.epc_out} !== {1'b1, 32'h3000})
         $display("FAIL prio_compare_exc got exl=%b epc=%h want exl=1 epc=3000", ia.exl_out, ia.epc_out);
      else n_pass++;
   endtask

   initial begin
      step();
      test_reset();
      test_count();
      test_timer();
      test_hw_irq();
      test_exception();
      test_priority();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
